// File: rtl/stream_mux_pkg.sv
// Shared types and helpers for the stream_mux_n N:1 streaming multiplexer.
package stream_mux_pkg;

    typedef enum logic [0:0] {
        MUX_IDLE   = 1'b0,
        MUX_LOCKED = 1'b1
    } mux_state_e;

    typedef enum logic [0:0] {
        MODE_SEL = 1'b0,
        MODE_RR  = 1'b1
    } mux_mode_e;

    // Next channel index, wrapping n-1 back to 0.
    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/stream_mux_n_rr_arbiter.sv
// Combinational round-robin arbiter: first requesting channel at or after ptr, wrapping.
module rr_arbiter
    import stream_mux_pkg::*;
#(
    parameter  int NUM_CH = 4,
    localparam int SEL_W  = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [SEL_W-1:0]  ptr,
    output logic [SEL_W-1:0]  gnt_idx,
    output logic              gnt_ok
);

    always_comb begin
        int idx;
        gnt_idx = '0;
        gnt_ok  = 1'b0;
        idx     = int'(ptr) % NUM_CH;
        for (int k = 0; k < NUM_CH; k++) begin
            if (!gnt_ok && req[idx]) begin
                gnt_ok  = 1'b1;
                gnt_idx = SEL_W'(idx);
            end
            idx = wrap_inc(idx, NUM_CH);
        end
    end

endmodule

// File: rtl/stream_mux_n.sv
// N:1 packet-locked streaming mux with a one-entry registered output stage.
// Define STREAM_MUX_RR_EN to compile in the round-robin arbiter (mode=1); otherwise mode is ignored.
module stream_mux_n
    import stream_mux_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int NUM_CH = 4,
    parameter int SEL_W  = $clog2(NUM_CH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH*WIDTH-1:0] in_data,
    input  logic [NUM_CH-1:0]       in_valid,
    input  logic [NUM_CH-1:0]       in_last,
    output logic [NUM_CH-1:0]       in_ready,
    input  logic [SEL_W-1:0]        select,
    input  logic                    mode,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    output logic                    out_last,
    output logic [SEL_W-1:0]        out_ch,
    input  logic                    out_ready
);

    mux_state_e        state_p1;
    logic [SEL_W-1:0]  lock_ch_p1;
    logic [WIDTH-1:0]  data_p1;
    logic              vld_p1;
    logic              last_p1;
    logic [SEL_W-1:0]  ch_p1;

    logic [SEL_W-1:0]  grant;
    logic              grant_ok;
    logic              explicit_ok;
    logic              load_en;
    logic              accept;
    logic [WIDTH-1:0]  sel_data;
    logic              sel_valid;
    logic              sel_last;

    assign explicit_ok = int'(select) < NUM_CH;

`ifdef STREAM_MUX_RR_EN
    logic [SEL_W-1:0] rr_ptr_p1;
    logic [SEL_W-1:0] rr_gnt;
    logic             rr_ok;

    rr_arbiter #(.NUM_CH(NUM_CH)) u_rr_arbiter (
        .req     (in_valid),
        .ptr     (rr_ptr_p1),
        .gnt_idx (rr_gnt),
        .gnt_ok  (rr_ok)
    );

    always_comb begin
        grant    = lock_ch_p1;
        grant_ok = 1'b1;
        if (state_p1 == MUX_IDLE) begin
            if (mux_mode_e'(mode) == MODE_RR) begin
                grant    = rr_gnt;
                grant_ok = rr_ok;
            end else begin
                grant    = select;
                grant_ok = explicit_ok;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_p1 <= '0;
        end else if (accept && sel_last) begin
            rr_ptr_p1 <= SEL_W'(wrap_inc(int'(grant), NUM_CH));
        end
    end
`else
    logic unused_mode;
    assign unused_mode = mode;

    always_comb begin
        grant    = lock_ch_p1;
        grant_ok = 1'b1;
        if (state_p1 == MUX_IDLE) begin
            grant    = select;
            grant_ok = explicit_ok;
        end
    end
`endif

    always_comb begin
        sel_data  = '0;
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (grant_ok && grant == SEL_W'(i)) begin
                sel_data  = in_data[i*WIDTH +: WIDTH];
                sel_valid = in_valid[i];
                sel_last  = in_last[i];
            end
        end
    end

    // Ready is withheld during reset so nothing is handshaken while state is being cleared.
    assign load_en = !vld_p1 || out_ready;
    assign accept  = !rst && load_en && grant_ok && sel_valid;

    always_comb begin
        in_ready = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            in_ready[i] = !rst && load_en && grant_ok && (grant == SEL_W'(i));
        end
    end

    // Stage p1: registered output beat and packet lock.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_p1   <= MUX_IDLE;
            lock_ch_p1 <= '0;
            vld_p1     <= 1'b0;
            data_p1    <= '0;
            last_p1    <= 1'b0;
            ch_p1      <= '0;
        end else if (accept) begin
            state_p1   <= sel_last ? MUX_IDLE : MUX_LOCKED;
            lock_ch_p1 <= grant;
            vld_p1     <= 1'b1;
            data_p1    <= sel_data;
            last_p1    <= sel_last;
            ch_p1      <= grant;
        end else if (out_ready) begin
            vld_p1     <= 1'b0;
        end
    end

    assign out_data  = data_p1;
    assign out_valid = vld_p1;
    assign out_last  = last_p1;
    assign out_ch    = ch_p1;

endmodule
